sobel_stream_ctrl: RTL and testbench
====================================

// Module: sobel_stream_ctrl
// PURPOSE
//  Sequencer for the Sobel convolution datapath. Accepts one AXI-Stream-style pixel frame.
//  Drives the conv core's stall, reset and input beat, tracks pipeline occupancy, and drains the pipe with zero beats at frame end.
//  Emits a framed output stream (SOF/EOL) with full backpressure.
//  Sits between the video input DMA and the conv core; the conv core is a lockstep pipeline without per-stage valids.
// PARAMETERS
//  PIXELS_PER_BEAT  8   pixels (8b each) per beat; DATA_WIDTH = 8*PIXELS_PER_BEAT
//  IMAGE_DIM        64  frame is IMAGE_DIM x IMAGE_DIM; IMAGE_DIM % PIXELS_PER_BEAT == 0
//  CONV_LAT         3   advances (incl. accepting one) until a beat is on conv_out; >= 1
// PORTS
//  clk           in   1    clock, all logic on posedge
//  reset         in   1    synchronous, active-high reset
//  enable        in   1    allow leaving IDLE
//  s_tdata       in   DW   input pixels
//  s_tvalid      in   1    input valid
//  s_tready      out  1    input ready
//  s_tuser       in   1    start of frame (first beat)
//  s_tlast       in   1    end of row
//  m_tdata       out  DW   output pixels (= conv_out)
//  m_tvalid      out  1    output valid
//  m_tready      in   1    output ready
//  m_tuser/m_tlast out 1   SOF / end of row on output
//  conv_aresetn  out  1    conv core reset (= ~reset)
//  conv_stall    out  1    conv core stall (= ~adv)
//  conv_in       out  DW   beat fed to conv core
//  conv_out      in   DW   conv core result
//  frame_done    out  1    1-cycle pulse after last output beat handshakes
//  busy          out  1    state != IDLE
//  err_tlast     out  1    sticky tlast mismatch (see CONFIGURATION)
// BEHAVIOUR
//  BPR = IMAGE_DIM/PIXELS_PER_BEAT beats per row; frame = IMAGE_DIM*BPR beats.
//  vsr[CONV_LAT-1:0] is the occupancy shift register, shifting on adv; m_tvalid = vsr[CONV_LAT-1].
//  ostall = m_tvalid & ~m_tready. The conv core is frozen while ostall, so m_tdata holds.
//  IDLE: s_tready = enable & ~ostall.
//   - Beats with s_tuser=0 are discarded (adv=0).
//   - Beat with s_tuser=1: adv=1, vsr[0]<=1, in_col/in_row advance, -> RUN.
//  RUN: adv = s_tvalid & ~ostall; s_tready = ~ostall; conv_in = s_tdata; vsr shifts in 1.
//   - The accepted beat with in_row=DIM-1, in_col=BPR-1 moves the FSM to FLUSH (in counters wrap to 0).
//   - s_tuser mid-frame is treated as data; the frame is not resynced.
//  FLUSH: s_tready=0; conv_in=0; adv = ~ostall & (fl_cnt < CONV_LAT-1); vsr shifts in 0.
//   - Handshake of the last output beat -> IDLE, vsr cleared, fl_cnt cleared, frame_done pulses next cycle.
//   - CONV_LAT=1: FLUSH issues no advances.
//  Output counters out_col/out_row advance on m_tvalid&m_tready, wrapping BPR-1 -> 0 and DIM-1 -> 0.
//   - m_tuser = (out_col==0 & out_row==0); m_tlast = (out_col==BPR-1).
//  conv_in = 0 whenever not RUN/IDLE-accept.
//  Input handshake and output handshake in the same cycle are legal; the conv pipe advances once.
//  Reset (any state): next cycle IDLE; vsr, counters, fl_cnt, err_tlast = 0.
//   - Outputs: s_tready=0, m_tvalid=0, conv_stall=1, frame_done=0, busy=0, conv_aresetn=0.
//   - A partial frame is dropped with no frame_done.
//  Counters: clog2(BPR) col and clog2(IMAGE_DIM) row bits, unsigned, exact wrap.
// CONFIGURATION
//  SOBEL_CTRL_TLAST_CHECK_EN defined:
//   - Each accepted input beat checks s_tlast == (in_col==BPR-1).
//   - A mismatch sets err_tlast (sticky until reset); the data path is unaffected.
//  Undefined: err_tlast tied 0, s_tlast ignored.
// STRUCTURE
//  sobel_pkg: state enum {IDLE,RUN,FLUSH}, function beats_per_row(), DATA_WIDTH rule.
//  Sub-module sobel_frame_counter: col/row counter with inc, wrap, and last_col/last_frame flags.
//   - Instantiated twice (input side, output side).
// TESTING (PPB=8, DIM=64 -> BPR=8, 512 beats, CONV_LAT=3)
//  - Full frame, m_tready=1, s_tvalid=1 from SOF:
//     512 outputs; m_tuser on beat 0 only; m_tlast every 8th beat.
//     2 flush advances with conv_in=0; frame_done 1 cycle after beat 512.
//  - Non-SOF beats 0x00..0x07 in IDLE: all accepted, conv_stall=1 throughout.
//     Then SOF beat: FSM enters RUN, vsr=001.
//  - Random m_tready (50%): no output beat lost or duplicated.
//     m_tdata stable while ostall; s_tready=0 during ostall.
//  - reset asserted at input beat 200:
//     next cycle IDLE, m_tvalid=0, conv_aresetn=0, no frame_done.
//     A following full frame is correct.
//  - With SOBEL_CTRL_TLAST_CHECK_EN, s_tlast on beat 5 of row 0:
//     err_tlast=1 stays set; output count still 512.
//  - Two back-to-back frames, SOF asserted while FLUSH of frame 1:
//     s_tready=0 until IDLE; frame 2 is accepted with its SOF beat.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel stream sequencer.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    function automatic int beats_per_row(input int dim, input int ppb);
        return dim / ppb;
    endfunction

    function automatic int data_width(input int ppb);
        return 8 * ppb;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_frame_counter.sv
// Column/row position counter with exact wrap and last-column/last-frame flags.
module sobel_frame_counter
    import sobel_pkg::*;
#(
    parameter int COLS = 8,
    parameter int ROWS = 64,
    localparam int CW = cnt_width(COLS),
    localparam int RW = cnt_width(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_col,
    output logic          last_frame
);

    assign last_col   = (col == CW'(COLS - 1));
    assign last_frame = last_col & (row == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (last_col) begin
                col <= '0;
                row <= last_frame ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Frame sequencer for the lockstep Sobel conv core: feed, drain, and frame the output.
// Optional input row-length check enabled by SOBEL_CTRL_TLAST_CHECK_EN.
module sobel_stream_ctrl
    import sobel_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 8,
    parameter int IMAGE_DIM       = 64,
    parameter int CONV_LAT        = 3,
    localparam int DW = data_width(PIXELS_PER_BEAT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_tuser,
    input  logic          s_tlast,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tuser,
    output logic          m_tlast,
    output logic          conv_aresetn,
    output logic          conv_stall,
    output logic [DW-1:0] conv_in,
    input  logic [DW-1:0] conv_out,
    output logic          frame_done,
    output logic          busy,
    output logic          err_tlast
);

    localparam int BPR = beats_per_row(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int CW  = cnt_width(BPR);
    localparam int RW  = cnt_width(IMAGE_DIM);
    localparam int FW  = cnt_width(CONV_LAT);

    state_t              state, state_nx;
    logic [CONV_LAT-1:0] vsr;
    logic [CONV_LAT:0]   vsr_sh;
    logic [FW-1:0]       fl_cnt;
    logic                adv, vsr_in, in_acc, ostall, out_hs, done_q;
    logic [CW-1:0]       in_col, out_col;
    logic [RW-1:0]       in_row, out_row;
    logic                in_last_col, in_last_frame;
    logic                out_last_col, out_last_frame;
    logic                unused_in;

    assign m_tvalid     = vsr[CONV_LAT-1] & ~reset;
    assign ostall       = m_tvalid & ~m_tready;
    assign out_hs       = m_tvalid & m_tready;
    assign m_tdata      = conv_out;
    assign m_tuser      = (out_col == '0) & (out_row == '0);
    assign m_tlast      = out_last_col;
    assign conv_aresetn = ~reset;
    assign conv_stall   = ~adv;
    assign frame_done   = done_q & ~reset;
    assign busy         = (state != IDLE) & ~reset;
    assign vsr_sh       = {vsr, vsr_in};
    assign unused_in    = ^{in_col, in_row};

    always_comb begin
        state_nx = state;
        adv      = 1'b0;
        vsr_in   = 1'b0;
        in_acc   = 1'b0;
        s_tready = 1'b0;
        conv_in  = '0;
        unique case (state)
            IDLE: begin
                s_tready = enable & ~ostall;
                // Only a SOF beat starts a frame; anything else is dropped.
                if (s_tvalid & enable & ~ostall & s_tuser) begin
                    adv      = 1'b1;
                    vsr_in   = 1'b1;
                    in_acc   = 1'b1;
                    conv_in  = s_tdata;
                    state_nx = RUN;
                end
            end
            RUN: begin
                s_tready = ~ostall;
                adv      = s_tvalid & ~ostall;
                vsr_in   = 1'b1;
                in_acc   = adv;
                conv_in  = s_tdata;
                if (adv & in_last_frame) state_nx = FLUSH;
            end
            FLUSH: begin
                adv = ~ostall & (fl_cnt < FW'(CONV_LAT - 1));
                if (out_hs & out_last_frame) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (reset) begin
            state_nx = IDLE;
            adv      = 1'b0;
            in_acc   = 1'b0;
            s_tready = 1'b0;
            conv_in  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            vsr    <= '0;
            fl_cnt <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (state == FLUSH) && (state_nx == IDLE);
            if ((state == FLUSH) && (state_nx == IDLE)) begin
                vsr    <= '0;
                fl_cnt <= '0;
            end else begin
                if (adv) vsr <= vsr_sh[CONV_LAT-1:0];
                if (adv && (state == FLUSH)) fl_cnt <= fl_cnt + 1'b1;
            end
        end
    end

    sobel_frame_counter #(
        .COLS(BPR),
        .ROWS(IMAGE_DIM)
    ) u_in_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (in_acc),
        .col       (in_col),
        .row       (in_row),
        .last_col  (in_last_col),
        .last_frame(in_last_frame)
    );

    sobel_frame_counter #(
        .COLS(BPR),
        .ROWS(IMAGE_DIM)
    ) u_out_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (out_hs),
        .col       (out_col),
        .row       (out_row),
        .last_col  (out_last_col),
        .last_frame(out_last_frame)
    );

`ifdef SOBEL_CTRL_TLAST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else if (in_acc && (s_tlast != in_last_col)) err_q <= 1'b1;
    end

    assign err_tlast = err_q;
`else
    logic unused_tlast;

    assign unused_tlast = s_tlast;
    assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Bench for sobel_stream_ctrl: conv core model, frame scoreboard, directed frames.
module tb_sobel_stream_ctrl;

    localparam int PPB   = 8;
    localparam int DIM   = 64;
    localparam int LAT   = 3;
    localparam int DW    = 64;
    localparam int BPR   = DIM / PPB;
    localparam int FRAME = DIM * BPR;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tuser, s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tuser, m_tlast;
    logic          m_tready = 1'b0;
    logic          conv_aresetn, conv_stall;
    logic [DW-1:0] conv_in, conv_out;
    logic          frame_done, busy, err_tlast;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] expq[$];
    int            out_idx = 0;
    bit            fd_due = 1'b0;
    int            fd_count = 0;
    bit            track_flush = 1'b0;
    int            flush_adv = 0;
    bit            prev_ostall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            rnd_mode = 1'b0;
    int            n_out, n_user, n_last;
    logic [DW-1:0] first_d, last_d;
    logic [DW-1:0] pipe[LAT];

`ifdef SOBEL_CTRL_TLAST_CHECK_EN
    localparam int  BAD_BEAT = 5;
    localparam logic EXP_ERR = 1'b1;
`else
    localparam int  BAD_BEAT = -1;
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    sobel_stream_ctrl #(
        .PIXELS_PER_BEAT(PPB),
        .IMAGE_DIM      (DIM),
        .CONV_LAT       (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tuser     (s_tuser),
        .s_tlast     (s_tlast),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tuser     (m_tuser),
        .m_tlast     (m_tlast),
        .conv_aresetn(conv_aresetn),
        .conv_stall  (conv_stall),
        .conv_in     (conv_in),
        .conv_out    (conv_out),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_tlast   (err_tlast)
    );

    // Lockstep conv core stand-in: LAT stages, frozen while stalled.
    always @(posedge clk) begin
        if (!conv_aresetn) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (!conv_stall) begin
            pipe[0] <= conv_in;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign conv_out = pipe[LAT-1];

    always @(posedge clk) begin
        #1;
        m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input logic [7:0] id, input int i);
        return {id, 40'h0, 16'(i)};
    endfunction

    always @(negedge clk) begin
        bit fd_now;
        logic [DW-1:0] e;
        fd_now = fd_due;
        fd_due = 1'b0;
        if (reset) begin
            prev_ostall = 1'b0;
        end else begin
            chk("frame_done", 64'(frame_done), 64'(fd_now));
            if (frame_done) begin
                fd_count++;
                if (track_flush) chk("flush_advances", 64'(flush_adv), 64'(LAT - 1));
                track_flush = 1'b0;
                flush_adv = 0;
            end else if (track_flush && !conv_stall) begin
                flush_adv++;
                chk("flush_conv_in", conv_in, 64'h0);
            end
            if (prev_ostall) begin
                chk("hold_valid", 64'(m_tvalid), 64'h1);
                chk("hold_data", m_tdata, prev_data);
            end
            if (m_tvalid && !m_tready) chk("ostall_s_tready", 64'(s_tready), 64'h0);
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out", m_tdata, 64'hx);
                end else begin
                    e = expq.pop_front();
                    chk("m_tdata", m_tdata, e);
                end
                chk("m_tuser", 64'(m_tuser), 64'(out_idx == 0));
                chk("m_tlast", 64'(m_tlast), 64'(out_idx % BPR == BPR - 1));
                if (n_out == 0) first_d = m_tdata;
                last_d = m_tdata;
                n_out++;
                n_user += int'(m_tuser);
                n_last += int'(m_tlast);
                if (out_idx == FRAME - 1) begin
                    fd_due = 1'b1;
                    out_idx = 0;
                end else begin
                    out_idx++;
                end
            end
            prev_ostall = m_tvalid & ~m_tready;
            prev_data = m_tdata;
        end
    end

    // stall_chk: 0 none, 1 expect stalled, 2 expect advance; busy_chk: -1 none
    task automatic send(input logic [DW-1:0] d, input logic u, input logic l,
                        input bit push, input int stall_chk, input int busy_chk,
                        input bit idle_chk);
        int n;
        n = 0;
        s_tdata = d;
        s_tuser = u;
        s_tlast = l;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (idle_chk) chk("sof_wait_s_tready", 64'(s_tready), 64'(!busy));
            if (s_tready) break;
            n++;
            if (n > 5000) begin
                chk("s_tready_timeout", 64'h0, 64'h1);
                break;
            end
        end
        if (stall_chk == 1) chk("idle_conv_stall", 64'(conv_stall), 64'h1);
        if (stall_chk == 2) chk("sof_conv_stall", 64'(conv_stall), 64'h0);
        if (busy_chk >= 0) chk("busy", 64'(busy), 64'(busy_chk));
        if (push) expq.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] id, input int nbeats,
                              input bit idle_chk);
        for (int i = 0; i < nbeats; i++) begin
            send(beat(id, i), i == 0, (i % BPR == BPR - 1) ^ (i == BAD_BEAT),
                 1'b1, (i == 0) ? 2 : 0, (i == 1) ? 1 : -1,
                 idle_chk && (i == 0));
        end
        if (nbeats == FRAME) track_flush = 1'b1;
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        for (int k = 0; k < 40000 && fd_count < target; k++) @(negedge clk);
        chk("frames_done", 64'(fd_count), 64'(target));
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        n_out = 0;
        n_user = 0;
        n_last = 0;
        first_d = '0;
        last_d = '0;
    endtask

    task automatic chk_stats(input int frames, input logic [DW-1:0] f,
                             input logic [DW-1:0] l);
        chk("out_count", 64'(n_out), 64'(frames * 512));
        chk("tuser_count", 64'(n_user), 64'(frames));
        chk("tlast_count", 64'(n_last), 64'(frames * 64));
        chk("first_data", first_d, f);
        chk("last_data", last_d, l);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        s_tdata = '0;
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        clr_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'h0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst_conv_stall", 64'(conv_stall), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_frame_done", 64'(frame_done), 64'h0);
        chk("rst_aresetn", 64'(conv_aresetn), 64'h0);
        chk("rst_err_tlast", 64'(err_tlast), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        enable = 1'b1;

        // Non-SOF beats in IDLE are swallowed without advancing the core.
        for (int i = 0; i < 8; i++) send(64'(i), 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        send_frame(8'hA1, FRAME, 1'b0);
        wait_frames(1);
        chk_stats(1, 64'hA100_0000_0000_0000, 64'hA100_0000_0000_01FF);
        chk("err_tlast_a", 64'(err_tlast), 64'(EXP_ERR));

        clr_stats();
        rnd_mode = 1'b1;
        send_frame(8'hB2, FRAME, 1'b0);
        wait_frames(2);
        chk_stats(1, 64'hB200_0000_0000_0000, 64'hB200_0000_0000_01FF);
        chk("err_tlast_sticky", 64'(err_tlast), 64'(EXP_ERR));

        rnd_mode = 1'b0;
        send_frame(8'hC3, 200, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("mid_rst_aresetn", 64'(conv_aresetn), 64'h0);
        chk("mid_rst_s_tready", 64'(s_tready), 64'h0);
        expq.delete();
        out_idx = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("post_rst_err", 64'(err_tlast), 64'h0);
        repeat (10) @(negedge clk);
        chk("no_partial_done", 64'(fd_count), 64'h2);
        @(posedge clk);
        #1;

        clr_stats();
        send_frame(8'hD4, FRAME, 1'b0);
        wait_frames(3);
        chk_stats(1, 64'hD400_0000_0000_0000, 64'hD400_0000_0000_01FF);

        // Second SOF is presented while the first frame is still draining.
        clr_stats();
        send_frame(8'hE5, FRAME, 1'b0);
        send_frame(8'hF6, FRAME, 1'b1);
        wait_frames(5);
        chk_stats(2, 64'hE500_0000_0000_0000, 64'hF600_0000_0000_01FF);
        chk("queue_empty", 64'(expq.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
